// File: rtl/scr_pkg.sv
// rtl/scr_pkg.sv - shared types and request decode for the scratch/stack RAM
//   state_t   : controller state (init sweep / normal run)
//   op_t      : one operation per cycle, decoded from the request pins
//   decode_op : priority decode of PUSH/POP requests into op_t
package scr_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_DIRECT,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } op_t;

    // PUSH+POP on an empty stack falls through to OP_POP so it raises UNF.
    function automatic op_t decode_op(input logic run,
                                      input logic push,
                                      input logic pop,
                                      input logic empty);
        op_t op;
        if (!run) begin
            op = OP_NONE;
        end else if (push && pop && !empty) begin
            op = OP_REPL;
        end else if (push && !pop) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end else begin
            op = OP_DIRECT;
        end
        return op;
    endfunction

endpackage

// File: rtl/scr_mem_1rw.sv
// rtl/scr_mem_1rw.sv - single-port synchronous read-first RAM
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr]
//   re    : read enable, captures old mem[addr] into rdata (holds otherwise)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data
module scr_mem_1rw #(
    parameter  int DATA_W = 10,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on purpose so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[addr];
        end
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scratch_stack_ram.sv
// rtl/scratch_stack_ram.sv - scratch RAM with hardware stack, flags and zero-fill sweep
//   CLK/RST_N  : clock, async active-low reset
//   DATA_IN    : write data for direct write or PUSH
//   SCR_ADDR   : direct address; SCR_WE direct write enable
//   PUSH/POP   : stack requests; CLR_ERR clears OVF/UNF
//   DATA_OUT   : registered read data
//   SP_OUT     : stack pointer; COUNT occupancy 0..DEPTH; FULL/EMPTY
//   OVF/UNF    : sticky overflow/underflow; BUSY zero-fill sweep active
module scratch_stack_ram
    import scr_pkg::*;
#(
    parameter  int DATA_W = 10,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [ADDR_W-1:0] SCR_ADDR,
    input  logic              SCR_WE,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVF,
    output logic              UNF,
    output logic              BUSY
);

    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    // Set once any read has landed in the RAM output register; until then
    // that register holds uninitialised data and DATA_OUT must read as 0.
    logic              rd_sel_q, rd_sel_d;

    logic              full, empty;
    op_t               op;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign op    = decode_op(state_q == ST_RUN, PUSH, POP, empty);

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        sp_d      = sp_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        rd_sel_d  = rd_sel_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = SCR_ADDR;
        mem_wdata = DATA_IN;

        // Clear first so a same-cycle set below takes priority.
        if (op != OP_NONE && CLR_ERR) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        case (op)
            OP_NONE: begin
                mem_addr  = sweep_q;
                mem_we    = 1'b1;
                mem_wdata = '0;
                sweep_d   = sweep_q + ADDR_W'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            OP_DIRECT: begin
                mem_addr = SCR_ADDR;
                mem_we   = SCR_WE;
                mem_re   = 1'b1;
                rd_sel_d = 1'b1;
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    // Stack grows downward: pre-decrement, then write.
                    mem_addr = sp_q - ADDR_W'(1);
                    mem_we   = 1'b1;
                    sp_d     = sp_q - ADDR_W'(1);
                    count_d  = count_q + (ADDR_W + 1)'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    mem_addr = sp_q;
                    mem_re   = 1'b1;
                    rd_sel_d = 1'b1;
                    sp_d     = sp_q + ADDR_W'(1);
                    count_d  = count_q - (ADDR_W + 1)'(1);
                end
            end
            OP_REPL: begin
                mem_addr = sp_q;
                mem_we   = 1'b1;
                mem_re   = 1'b1;
                rd_sel_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            sp_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            sp_q     <= sp_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    scr_mem_1rw #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign DATA_OUT = rd_sel_q ? mem_rdata : '0;
    assign SP_OUT   = sp_q;
    assign COUNT    = count_q;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign OVF      = ovf_q;
    assign UNF      = unf_q;
    assign BUSY     = (state_q == ST_INIT);

endmodule
